store_packer: RTL and testbench
===============================

// Module: store_packer
// PURPOSE
//  Store-side counterpart of the immediate/load extender. The extender widens 16-bit values to 32 bits; this block narrows.
//  - Accepts sw/sh/sb requests from the MEM stage.
//  - Places the byte or halfword on its little-endian byte lanes and generates 4-bit byte enables.
//  - Buffers requests in a small FIFO and issues them to data memory with a valid/ready handshake.
// PARAMETERS
//  DEPTH   2   FIFO entries; power of 2, >=2
//  ADDR_W  32  address width
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  req_valid  in   1       store request valid
//  req_ready  out  1       FIFO can accept; equals !full
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      source register value; low bits used for byte/half stores
//  req_size   in   2       00=byte, 01=half, 10=word, 11=reserved (treated as word)
//  mem_valid  out  1       FIFO head valid (!empty)
//  mem_ready  in   1       memory accepts the head entry
//  mem_addr   out  ADDR_W  word-aligned address, addr[1:0]=00
//  mem_wdata  out  32      lane-aligned data
//  mem_be     out  4       byte enables; bit i covers wdata[8i+7:8i]
//  exc_valid  out  1       one-cycle misaligned-store pulse
//  exc_addr   out  ADDR_W  faulting byte address
//  level      out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; req_ready=1 once rst_n deasserts. Assertion mid-operation flushes the FIFO immediately.
//  Push: on req_valid&&req_ready. Pop: on mem_valid&&mem_ready.
//  Simultaneous push and pop are legal when not full; level is unchanged. No bypass when full (req_ready=0).
//  Latency: a request accepted in cycle N appears on mem_* in cycle N+1 at the earliest. All mem_* outputs are registered.
//  mem_addr/wdata/be hold stable while mem_valid && !mem_ready.
//  Lane alignment (o=addr[1:0]):
//    byte: wdata={4{d[7:0]}}, be=4'b0001<<o
//    half: wdata={2{d[15:0]}}, be = o[1] ? 1100 : 0011
//    word: wdata=d, be=1111
//  Misaligned: half with o[0]=1, or word/reserved with o!=0.
//  Pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//    full  = MSBs differ and the low bits are equal.
//    empty = pointers equal.
//  level wraps never; its range is 0..DEPTH.
// CONFIGURATION
//  `MISALIGN_EXC_EN defined:
//    - A misaligned request is still handshaken (subject to req_ready) but is not enqueued.
//    - exc_valid=1 in cycle N+1 for exactly one cycle, with exc_addr=req_addr.
//    - Back-to-back misaligned requests produce back-to-back pulses.
//  Not defined:
//    - addr[1:0] is masked to the natural alignment (half: o[0]=0; word: o=00) and the store proceeds.
//    - exc_valid and exc_addr are tied to 0.
// STRUCTURE
//  Shared constants file mem_defs.v: SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD encodings and the BE_* masks. The load extender uses the same file.
//  Sub-module store_lane_align (combinational): {size, addr[1:0], data} -> {wdata, be, misaligned}.
//  FIFO storage, pointers and handshake stay in store_packer.
// TESTING
//  1. sb addr=0x1003, d=0x000000AB, mem_ready=1
//     -> next cycle: mem_addr=0x1000, wdata=0xABABABAB, be=1000
//  2. sh addr=0x2002, d=0x1234
//     -> wdata=0x12341234, be=1100
//     sw addr=0x2004, d=0xDEADBEEF -> be=1111
//  3. mem_ready=0, push 3 words (DEPTH=2):
//     -> req_ready falls after 2 pushes; level=2; mem_* stable.
//     Then mem_ready=1 -> entries drain in order; req_ready rises.
//  4. Held full, then push+pop in the same cycle at level=1
//     -> level stays 1; the pointers wrap correctly over 10 cycles.
//  5. sh addr=0x3001 with macro -> exc_valid pulse, exc_addr=0x3001, level unchanged.
//     Without macro -> mem_addr=0x3000, be=0011.
//  6. rst_n low with 2 entries queued
//     -> mem_valid=0 and level=0 asynchronously; entries are never issued.

Source files
------------

// File: rtl/store_packer_pkg.sv
// Shared store-path encodings: access size codes, byte-enable masks and the lane-align result.
// Used by store_packer and store_lane_align.
package store_packer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mis;
    } lane_t;

endpackage

// File: rtl/store_packer_lane_align.sv
// store_lane_align: replicates byte/half data across the word and builds byte enables.
// Purely combinational; also flags accesses that break natural alignment.
module store_lane_align
    import store_packer_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output lane_t       lane_o
);

    always_comb begin
        lane_o.wdata = data_i;
        lane_o.be    = BE_WORD;
        lane_o.mis   = 1'b0;
        case (size_e'(size_i))
            SZ_BYTE: begin
                lane_o.wdata = {4{data_i[7:0]}};
                lane_o.be    = BE_B0 << addr_lo_i;
            end
            SZ_HALF: begin
                // Only o[1] selects the lane, so masking o[0] needs no extra logic.
                lane_o.wdata = {2{data_i[15:0]}};
                lane_o.be    = addr_lo_i[1] ? BE_HHI : BE_HLO;
                lane_o.mis   = addr_lo_i[0];
            end
            default: begin
                lane_o.wdata = data_i;
                lane_o.be    = BE_WORD;
                lane_o.mis   = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/store_packer.sv
// store_packer: lane-aligns sb/sh/sw requests and queues them for data memory (valid/ready).
// Define MISALIGN_EXC_EN to drop misaligned stores and pulse exc_valid instead of realigning.
module store_packer
    import store_packer_pkg::*;
#(
    parameter  int DEPTH  = 2,
    parameter  int ADDR_W = 32,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              exc_valid,
    output logic [ADDR_W-1:0] exc_addr,
    output logic [PW:0]       level
);

    lane_t lane;

    store_lane_align u_align (
        .size_i    (req_size),
        .addr_lo_i (req_addr[1:0]),
        .data_i    (req_wdata),
        .lane_o    (lane)
    );

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
    logic              full, empty, push_ok, enq, deq;

    assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign empty     = (wr_q == rd_q);
    assign req_ready = rst_n && !full;
    assign push_ok   = req_valid && req_ready;
    assign mem_valid = !empty;
    assign deq       = mem_valid && mem_ready;
    assign level     = wr_q - rd_q;

    assign mem_addr  = addr_q[rd_q[PW-1:0]];
    assign mem_wdata = data_q[rd_q[PW-1:0]];
    assign mem_be    = be_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = enq ? wr_q + 1'b1 : wr_q;
        rd_d = deq ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (enq) begin
                addr_q[wr_q[PW-1:0]] <= {req_addr[ADDR_W-1:2], 2'b00};
                data_q[wr_q[PW-1:0]] <= lane.wdata;
                be_q[wr_q[PW-1:0]]   <= lane.be;
            end
        end
    end

`ifdef MISALIGN_EXC_EN
    logic              exc_valid_q;
    logic [ADDR_W-1:0] exc_addr_q;

    // Misaligned stores are consumed by the handshake but never reach memory.
    assign enq = push_ok && !lane.mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            exc_valid_q <= push_ok && lane.mis;
            if (push_ok && lane.mis) exc_addr_q <= req_addr;
        end
    end

    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;
`else
    logic unused_mis;

    assign enq        = push_ok;
    assign exc_valid  = 1'b0;
    assign exc_addr   = '0;
    assign unused_mis = lane.mis;
`endif

endmodule

// File: tb/tb_store_packer.sv
// Scoreboard bench for store_packer: directed stores push expected memory beats,
// a negedge monitor pops and compares on every mem handshake and exception pulse.
module tb_store_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_valid;
    logic [31:0] exc_addr;
    logic [1:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [67:0] sbq [$];
    logic [31:0] excq [$];

    always #5 clk = ~clk;

    store_packer #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .exc_valid(exc_valid), .exc_addr(exc_addr), .level(level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one request until accepted; expected beat (or exception) enters the scoreboard at the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb,
                        input bit mis, input int elvl);
        bit acc = 0;
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_size = sz;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1;
                if (elvl >= 0) chk("push_level", 64'(level), 64'(elvl));
            end
        end
        if (!acc) chk("push_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        if (acc) begin
`ifdef MISALIGN_EXC_EN
            if (mis) excq.push_back(a);
            else     sbq.push_back({ea, ed, eb});
`else
            sbq.push_back({ea, ed, eb});
`endif
        end
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [67:0] e;
        if (rst_n && mem_valid && mem_ready) begin
            if (sbq.size() == 0) chk("unexpected_beat", 64'(mem_addr), 64'hFFFF_FFFF_FFFF);
            else begin
                e = sbq.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(e[67:36]));
                chk("mem_wdata", 64'(mem_wdata), 64'(e[35:4]));
                chk("mem_be", 64'(mem_be), 64'(e[3:0]));
            end
        end
        if (rst_n && exc_valid) begin
            if (excq.size() == 0) chk("unexpected_exc", 64'(exc_addr), 64'hFFFF_FFFF_FFFF);
            else chk("exc_addr", 64'(exc_addr), 64'(excq.pop_front()));
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_mem_be", 64'(mem_be), 64'd0);
        chk("idle_exc_valid", 64'(exc_valid), 64'd0);
        @(posedge clk); #1;

        // Byte and half/word lane placement, memory always ready.
        mem_ready = 1'b1;
        push(32'h1003, 32'h0000_00AB, 2'b00, 32'h1000, 32'hABAB_ABAB, 4'b1000, 0, 0);
        @(negedge clk);
        chk("latency_valid", 64'(mem_valid), 64'd1);
        @(posedge clk); #1;
        push(32'h1001, 32'h1234_5677, 2'b00, 32'h1000, 32'h7777_7777, 4'b0010, 0, -1);
        push(32'h1002, 32'h0000_00C5, 2'b00, 32'h1000, 32'hC5C5_C5C5, 4'b0100, 0, -1);
        push(32'h2002, 32'h0000_1234, 2'b01, 32'h2000, 32'h1234_1234, 4'b1100, 0, -1);
        push(32'h2000, 32'hFFFF_8001, 2'b01, 32'h2000, 32'h8001_8001, 4'b0011, 0, -1);
        push(32'h2004, 32'hDEAD_BEEF, 2'b10, 32'h2004, 32'hDEAD_BEEF, 4'b1111, 0, -1);
        push(32'h7000, 32'hCAFE_F00D, 2'b11, 32'h7000, 32'hCAFE_F00D, 4'b1111, 0, -1);
        cyc(3);

        // Fill with memory stalled, head must hold, then drain in order.
        mem_ready = 1'b0;
        push(32'h5000, 32'h1111_1111, 2'b10, 32'h5000, 32'h1111_1111, 4'b1111, 0, 0);
        push(32'h5004, 32'h2222_2222, 2'b10, 32'h5004, 32'h2222_2222, 4'b1111, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_req_ready", 64'(req_ready), 64'd0);
            chk("full_level", 64'(level), 64'd2);
            chk("hold_addr", 64'(mem_addr), 64'h5000);
            chk("hold_wdata", 64'(mem_wdata), 64'h1111_1111);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        push(32'h5008, 32'h3333_3333, 2'b10, 32'h5008, 32'h3333_3333, 4'b1111, 0, 1);
        cyc(4);
        chk("drained_level", 64'(level), 64'd0);

        // Full, then sustained push+pop at level 1 across pointer wrap.
        mem_ready = 1'b0;
        push(32'h6000, 32'hA000_0000, 2'b10, 32'h6000, 32'hA000_0000, 4'b1111, 0, 0);
        push(32'h6004, 32'hA000_0001, 2'b10, 32'h6004, 32'hA000_0001, 4'b1111, 0, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("pre_stream_level", 64'(level), 64'd2);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, d;
            a = 32'h6100 + 32'(4 * i);
            d = 32'hB000_0000 + 32'(i);
            push(a, d, 2'b10, a, d, 4'b1111, 0, 1);
        end
        cyc(3);

        // Misaligned half and word, back to back.
`ifdef MISALIGN_EXC_EN
        push(32'h3001, 32'h0000_5678, 2'b01, 32'h0, 32'h0, 4'h0, 1, 0);
        push(32'h3006, 32'h0BAD_F00D, 2'b10, 32'h0, 32'h0, 4'h0, 1, 0);
        @(negedge clk);
        chk("exc_level", 64'(level), 64'd0);
        chk("exc_no_beat", 64'(mem_valid), 64'd0);
        @(posedge clk); #1;
`else
        push(32'h3001, 32'h0000_5678, 2'b01, 32'h3000, 32'h5678_5678, 4'b0011, 1, 0);
        push(32'h3006, 32'h0BAD_F00D, 2'b10, 32'h3004, 32'h0BAD_F00D, 4'b1111, 1, -1);
`endif
        cyc(3);

        // Async reset with two entries queued: flushed, never issued.
        mem_ready = 1'b0;
        push(32'h8000, 32'h1, 2'b10, 32'h8000, 32'h1, 4'b1111, 0, 0);
        push(32'h8004, 32'h2, 2'b10, 32'h8004, 32'h2, 4'b1111, 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sbq.delete();
        #1 chk("flush_mem_valid", 64'(mem_valid), 64'd0);
        chk("flush_level", 64'(level), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_flush_valid", 64'(mem_valid), 64'd0);
            chk("post_flush_ready", 64'(req_ready), 64'd1);
        end

        for (int i = 0; i < 20 && (sbq.size() != 0 || excq.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("sb_leftover", 64'(sbq.size()), 64'd0);
        chk("exc_leftover", 64'(excq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
